// File: rtl/ysyx_220053_ifu.sv
// ysyx_220053_ifu: in-order fetch stage, one instruction in flight.
// Ports: imem req/resp bus, instr/pc to decode, dnpc back, error + count.
module ysyx_220053_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  input  logic [63:0] dnpc_i,
  output logic        fetch_err,
  output logic [1:0]  err_cause,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    ERR
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [63:0] pc_q;
  logic [15:0] timer_q;
  logic        misaligned;
  logic        tmo_hit;

  assign misaligned = |pc_q[1:0];
  assign tmo_hit    = (timer_q == TMO_LAST);

  // Outputs come only from state and registers.
  assign imem_req_valid = (state_q == REQ) && !misaligned;
  assign imem_req_addr  = {pc_q[63:3], 3'b000};
  assign instr_valid    = (state_q == OUT);
  assign fetch_err      = (state_q == ERR);
  assign pc_o           = pc_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (misaligned)          state_d = ERR;
        else if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        // A response in the last timer cycle beats the timeout.
        if (imem_resp_valid)
          state_d = imem_resp_err ? ERR : OUT;
        else if (tmo_hit)
          state_d = ERR;
      end
      OUT: begin
        if (instr_ready) state_d = REQ;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_o   <= '0;
      timer_q   <= '0;
      fetch_cnt <= '0;
      err_cause <= 2'b00;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        REQ: begin
          if (misaligned)          err_cause <= 2'b01;
          else if (imem_req_ready) timer_q   <= '0;
        end
        WAIT: begin
          if (imem_resp_valid) begin
            if (imem_resp_err)
              err_cause <= 2'b10;
            else if (pc_q[2])
              instr_o <= imem_resp_data[63:32];
            else
              instr_o <= imem_resp_data[31:0];
          end else if (tmo_hit) begin
            err_cause <= 2'b11;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        OUT: begin
          if (instr_ready) begin
            pc_q      <= dnpc_i;
            fetch_cnt <= fetch_cnt + 64'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
